// File: rtl/qspi_arbiter_if.sv
// Bus bundle between the fetch/memory requesters, the QSPI engine and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface qspi_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [31:0]       f_data;

  logic              m_req;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata;
  logic              m_ack;
  logic [15:0]       m_rdata;

  logic              err;

  logic              q_start;
  logic              q_write;
  logic [ADDR_W-1:0] q_addr;
  logic [15:0]       q_wdata;
  logic [31:0]       q_rdata;
  logic              q_busy;
  logic              q_cs_n;

  logic              cs_rom_n;
  logic              cs_ram_n;

  modport slave (
    input  f_req, f_addr, m_req, m_write, m_addr, m_wdata,
    input  q_rdata, q_busy, q_cs_n,
    output f_ack, f_data, m_ack, m_rdata, err,
    output q_start, q_write, q_addr, q_wdata,
    output cs_rom_n, cs_ram_n
  );

  modport master (
    output f_req, f_addr, m_req, m_write, m_addr, m_wdata,
    output q_rdata, q_busy, q_cs_n,
    input  f_ack, f_data, m_ack, m_rdata, err,
    input  q_start, q_write, q_addr, q_wdata,
    input  cs_rom_n, cs_ram_n
  );
endinterface

// File: rtl/qspi_arbiter.sv
// Round-robin arbiter sharing one QSPI engine between instruction fetch (flash)
// and data memory (PSRAM); one transaction in flight, aborted on engine timeout.
module qspi_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  qspi_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_e;

  // Counter reads 0 in the first wait cycle, so abort fires TIMEOUT cycles after ISSUE.
  localparam logic [7:0] TMO_LAST = (TIMEOUT >= 2) ? 8'(TIMEOUT - 2) : 8'd0;

  state_e            state_q;
  logic              gnt_mem_q;
  logic              last_mem_q;
  logic [7:0]        cnt_q;
  logic              q_start_q;
  logic              q_write_q;
  logic [ADDR_W-1:0] q_addr_q;
  logic [15:0]       q_wdata_q;
  logic              f_ack_q;
  logic              m_ack_q;
  logic              err_q;
  logic [31:0]       f_data_q;
  logic [15:0]       m_rdata_q;

  logic              gnt_mem_d;
  logic              tmo_hit;
  logic              active;

  always_comb begin
    gnt_mem_d = bus.m_req && (!bus.f_req || !last_mem_q);
  end

  assign tmo_hit = (cnt_q == TMO_LAST);
  assign active  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_mem_q  <= 1'b0;
      last_mem_q <= 1'b0;
      cnt_q      <= '0;
      q_start_q  <= 1'b0;
      q_write_q  <= 1'b0;
      q_addr_q   <= '0;
      q_wdata_q  <= '0;
      f_ack_q    <= 1'b0;
      m_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      f_data_q   <= '0;
      m_rdata_q  <= '0;
    end else begin
      q_start_q <= 1'b0;
      f_ack_q   <= 1'b0;
      m_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      f_data_q  <= '0;
      m_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.f_req || bus.m_req) begin
            gnt_mem_q  <= gnt_mem_d;
            last_mem_q <= gnt_mem_d;
            q_addr_q   <= gnt_mem_d ? bus.m_addr : bus.f_addr;
            q_write_q  <= gnt_mem_d && bus.m_write;
            q_wdata_q  <= gnt_mem_d ? bus.m_wdata : 16'h0000;
            q_start_q  <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          cnt_q <= cnt_q + 8'd1;
          if ((state_q == WAIT_BUSY) && bus.q_busy) begin
            state_q <= WAIT_DONE;
          end else if ((state_q == WAIT_DONE) && !bus.q_busy) begin
            state_q   <= ACK;
            f_ack_q   <= !gnt_mem_q;
            m_ack_q   <= gnt_mem_q;
            f_data_q  <= gnt_mem_q ? 32'h0 : bus.q_rdata;
            m_rdata_q <= gnt_mem_q ? bus.q_rdata[15:0] : 16'h0000;
          end else if (tmo_hit) begin
            // Aborted: ack the grantee with err set and zeroed data.
            state_q <= ACK;
            f_ack_q <= !gnt_mem_q;
            m_ack_q <= gnt_mem_q;
            err_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.q_start  = q_start_q;
  assign bus.q_write  = q_write_q;
  assign bus.q_addr   = q_addr_q;
  assign bus.q_wdata  = q_wdata_q;
  assign bus.f_ack    = f_ack_q;
  assign bus.m_ack    = m_ack_q;
  assign bus.err      = err_q;
  assign bus.f_data   = f_data_q;
  assign bus.m_rdata  = m_rdata_q;
  // Only the grantee sees the engine's chip select; the other device stays deselected.
  assign bus.cs_rom_n = (active && !gnt_mem_q) ? bus.q_cs_n : 1'b1;
  assign bus.cs_ram_n = (active &&  gnt_mem_q) ? bus.q_cs_n : 1'b1;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Directed bench for qspi_arbiter: behavioural QSPI engine, hand-computed
// expectations for fetch, memory, round-robin, timeout and reset scenarios.
module tb_qspi_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   eng_len = 1;

  always #5 clk = ~clk;

  qspi_arbiter_if #(.ADDR_W(24)) bus ();

  qspi_arbiter #(.ADDR_W(24), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Engine: busy (and chip select) for eng_len cycles, starting the cycle after q_start.
  initial begin
    bus.q_busy = 1'b0;
    bus.q_cs_n = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.q_start && eng_len > 0) begin
        @(posedge clk);
        #1;
        bus.q_busy = 1'b1;
        bus.q_cs_n = 1'b0;
        repeat (eng_len) @(posedge clk);
        #1;
        bus.q_busy = 1'b0;
        bus.q_cs_n = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic run_txn(input string tag, input bit exp_mem, input logic [31:0] exp_data,
                         input bit exp_err, input int exp_lat, input logic [23:0] exp_addr,
                         input bit exp_wr, input logic [15:0] exp_wd);
    int          starts = 0;
    bit          seen = 1'b0;
    int          lat = -1;
    logic [23:0] st_addr = '0;
    logic        st_wr = 1'b0;
    logic [15:0] st_wd = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      chk({tag, "_cs_other"}, 32'(exp_mem ? bus.cs_rom_n : bus.cs_ram_n), 32'd1);
      chk({tag, "_cs_own"}, 32'(exp_mem ? bus.cs_ram_n : bus.cs_rom_n), 32'(bus.q_cs_n));
      if (bus.q_start) begin
        starts++;
        st_addr = bus.q_addr;
        st_wr   = bus.q_write;
        st_wd   = bus.q_wdata;
      end
      if (bus.f_ack || bus.m_ack) begin
        seen = 1'b1;
        lat  = c;
        chk({tag, "_f_ack"}, 32'(bus.f_ack), 32'(!exp_mem));
        chk({tag, "_m_ack"}, 32'(bus.m_ack), 32'(exp_mem));
        chk({tag, "_data"}, exp_mem ? 32'(bus.m_rdata) : bus.f_data, exp_data);
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_addr_hold"}, 32'(bus.q_addr), 32'(exp_addr));
        chk({tag, "_wr_hold"}, 32'(bus.q_write), 32'(exp_wr));
      end
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    chk({tag, "_starts"}, 32'(starts), 32'd1);
    chk({tag, "_q_addr"}, 32'(st_addr), 32'(exp_addr));
    chk({tag, "_q_write"}, 32'(st_wr), 32'(exp_wr));
    if (exp_mem) chk({tag, "_q_wdata"}, 32'(st_wd), 32'(exp_wd));
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    if (exp_mem) bus.m_req = 1'b0;
    else         bus.f_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_q_start"}, 32'(bus.q_start), 32'd0);
    chk({tag, "_q_write"}, 32'(bus.q_write), 32'd0);
    chk({tag, "_q_addr"}, 32'(bus.q_addr), 32'd0);
    chk({tag, "_q_wdata"}, 32'(bus.q_wdata), 32'd0);
    chk({tag, "_f_ack"}, 32'(bus.f_ack), 32'd0);
    chk({tag, "_m_ack"}, 32'(bus.m_ack), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_f_data"}, bus.f_data, 32'd0);
    chk({tag, "_m_rdata"}, 32'(bus.m_rdata), 32'd0);
    chk({tag, "_cs_rom_n"}, 32'(bus.cs_rom_n), 32'd1);
    chk({tag, "_cs_ram_n"}, 32'(bus.cs_ram_n), 32'd1);
  endtask

  initial begin
    bit got;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.m_req   = 1'b0;
    bus.m_write = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.q_rdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");

    // Single fetch, engine busy 3 cycles
    @(posedge clk);
    #1;
    rst         = 1'b0;
    eng_len     = 3;
    bus.q_rdata = 32'hDEADBEEF;
    bus.f_addr  = 24'h000100;
    bus.f_req   = 1'b1;
    run_txn("fetch", 1'b0, 32'hDEADBEEF, 1'b0, 6, 24'h000100, 1'b0, 16'h0);

    // Memory read; operands changed mid-transaction must not leak through
    eng_len     = 1;
    bus.q_rdata = 32'h12345678;
    bus.m_addr  = 24'h000010;
    bus.m_write = 1'b0;
    bus.m_wdata = 16'h1357;
    bus.m_req   = 1'b1;
    fork
      run_txn("mrd", 1'b1, 32'h00005678, 1'b0, 4, 24'h000010, 1'b0, 16'h1357);
      begin
        repeat (2) @(posedge clk);
        #2;
        bus.m_addr  = 24'hFFFFFF;
        bus.m_wdata = 16'hFFFF;
        bus.m_write = 1'b1;
      end
    join

    // Engine never goes busy: abort 8 cycles after ISSUE
    eng_len     = 0;
    bus.q_rdata = 32'hCAFEF00D;
    bus.f_addr  = 24'h000300;
    bus.f_req   = 1'b1;
    run_txn("tmo", 1'b0, 32'h0, 1'b1, 9, 24'h000300, 1'b0, 16'h0);
    @(negedge clk);
    chk("tmo_after_cs_rom_n", 32'(bus.cs_rom_n), 32'd1);
    chk("tmo_after_cs_ram_n", 32'(bus.cs_ram_n), 32'd1);
    chk("tmo_after_err", 32'(bus.err), 32'd0);

    // Tie after reset: memory first, then fetch wins the re-tie, then memory alone
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    eng_len     = 1;
    bus.q_rdata = 32'h11112222;
    bus.f_addr  = 24'h000200;
    bus.f_req   = 1'b1;
    bus.m_addr  = 24'h012345;
    bus.m_write = 1'b1;
    bus.m_wdata = 16'hA5A5;
    bus.m_req   = 1'b1;
    run_txn("tie_m", 1'b1, 32'h00002222, 1'b0, 4, 24'h012345, 1'b1, 16'hA5A5);
    bus.m_addr  = 24'h000040;
    bus.m_write = 1'b0;
    bus.m_wdata = 16'h0042;
    bus.m_req   = 1'b1;
    run_txn("tie_f", 1'b0, 32'h11112222, 1'b0, 4, 24'h000200, 1'b0, 16'h0);
    run_txn("rr_m", 1'b1, 32'h00002222, 1'b0, 4, 24'h000040, 1'b0, 16'h0042);

    // Reset while in WAIT_DONE
    eng_len    = 5;
    bus.f_addr = 24'h000500;
    bus.f_req  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.q_start) got = 1'b1;
    end
    chk("rstmid_start_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.f_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstmid_no_ack", 32'({bus.f_ack, bus.m_ack}), 32'd0);
    end

    // Fresh fetch after reset completes normally
    @(posedge clk);
    #1;
    eng_len     = 1;
    bus.q_rdata = 32'h0BADCAFE;
    bus.f_addr  = 24'h000600;
    bus.f_req   = 1'b1;
    run_txn("post_rst", 1'b0, 32'h0BADCAFE, 1'b0, 4, 24'h000600, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
